// File: rtl/mmio_hub_pkg.sv
// Shared constants for the MMIO hub: register offsets, flag/control bit
// positions, access patterns and a byte-lane merge helper.
package mmio_pkg;

  localparam logic [7:0] OFF_SW     = 8'h00;
  localparam logic [7:0] OFF_SEG7   = 8'h04;
  localparam logic [7:0] OFF_LED    = 8'h08;
  localparam logic [7:0] OFF_TIMER  = 8'h0C;
  localparam logic [7:0] OFF_CMP    = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;
  localparam logic [7:0] OFF_CTRL   = 8'h18;

  localparam int ST_MATCH = 0;
  localparam int ST_SWCHG = 1;
  localparam int ST_ERR   = 2;

  localparam int CT_TEN      = 0;
  localparam int CT_IE_MATCH = 1;
  localparam int CT_IE_SWCHG = 2;
  localparam int CT_IE_ERR   = 3;

  localparam logic [3:0] AMP_W = 4'b1111;
  localparam logic [3:0] AMP_H = 4'b0011;
  localparam logic [3:0] AMP_B = 4'b0001;

  // Replace only the byte lanes selected by be.
  function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                             input logic [31:0] wr,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wr[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_hub_if.sv
// CPU data port and data-RAM port of the MMIO hub, bundled as one interface.
interface mmio_hub_if #(parameter int RAM_AW = 7);

  logic              cpu_we_i;
  logic [31:0]       cpu_addr_i;
  logic [31:0]       cpu_wdata_i;
  logic [3:0]        cpu_amp_i;
  logic [31:0]       cpu_rdata_o;
  logic              ram_we_o;
  logic [3:0]        ram_be_o;
  logic [RAM_AW-1:0] ram_addr_o;
  logic [31:0]       ram_wdata_o;
  logic [31:0]       ram_rdata_i;

  // Hub side.
  modport slave (
    input  cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_amp_i, ram_rdata_i,
    output cpu_rdata_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
  );

  // CPU + RAM side.
  modport master (
    output cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_amp_i, ram_rdata_i,
    input  cpu_rdata_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
  );

endinterface

// File: rtl/mmio_hub_sw_debounce.sv
// Switch debouncer: 2-flop synchroniser, then a candidate value that must stay
// stable for CYCLES cycles before it is accepted. chg_o pulses for the one
// cycle whose closing edge loads a different value into db_o.
module sw_debounce #(
  parameter int W      = 16,
  parameter int CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] db_o,
  output logic         chg_o
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
  localparam logic [CW-1:0] PRE  = CW'(CYCLES - 2);

  logic [W-1:0]  sync1, sync2, cand;
  logic [CW-1:0] cnt;
  logic          load;

  // The counter becomes LAST on the same edge that accepts the candidate,
  // so a stable input lands in db_o 2 + CYCLES edges after it settles.
  always_comb begin
    load  = (sync2 == cand) && (cnt == PRE);
    chg_o = load && (cand != db_o);
  end

  // Synchroniser, candidate tracking, stability counter and accepted value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
      db_o  <= '0;
    end else begin
      sync1 <= raw_i;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != LAST) begin
        cnt <= cnt + 1'b1;
        if (load) db_o <= cand;
      end
    end
  end

endmodule

// File: rtl/mmio_hub.sv
// MMIO hub: decodes CPU accesses into the data RAM or a small I/O register
// file (switches, SEG7, LEDs, timer/compare, sticky status, control) and
// drives a registered level interrupt.
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int          RAM_AW     = 7,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
  parameter int          SW_W       = 16,
  parameter int          LED_W      = 16,
  parameter int          DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  mmio_hub_if.slave        bus,
  input  logic [SW_W-1:0]  sw_i,
  output logic [LED_W-1:0] led_o,
  output logic [31:0]      seg7_data_o,
  output logic             seg7_we_o,
  output logic             irq_o
);

  localparam logic [31:0] RAM_BYTES = 32'(4 * (2 ** RAM_AW));

  logic [1:0]  off;
  logic [4:0]  sh;
  logic        is_io, is_ram, misal, ok, err_wr, io_we;
  logic [3:0]  be;
  logic [31:0] wsh;
  logic [15:0] io_word;
  logic        sel_seg7, sel_led, sel_timer, sel_cmp, sel_status, sel_ctrl;

  logic [31:0] timer, cmp;
  logic [3:0]  ctrl;
  logic [2:0]  status;
  logic [2:0]  st_set, st_clr;
  logic        match_hit;
  logic [SW_W-1:0] sw_db;
  logic        sw_chg;
  logic [31:0] sw_word, led_word, io_rd;

  sw_debounce #(.W(SW_W), .CYCLES(DEB_CYCLES)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .raw_i (sw_i),
    .db_o  (sw_db),
    .chg_o (sw_chg)
  );

  // Address decode, alignment check and RAM-side lane steering.
  always_comb begin
    off     = bus.cpu_addr_i[1:0];
    sh      = {off, 3'b000};
    is_io   = (bus.cpu_addr_i[31:16] == IO_BASE[31:16]);
    is_ram  = !is_io && (bus.cpu_addr_i < RAM_BYTES);
    misal   = ((bus.cpu_amp_i == AMP_H) && (off == 2'd3)) ||
              ((bus.cpu_amp_i == AMP_W) && (off != 2'd0));
    ok      = (is_io || is_ram) && !misal;
    // Without a read strobe a stray address on an idle bus would flag ERR,
    // so only stores are treated as error events.
    err_wr  = bus.cpu_we_i && !ok;
    io_we   = bus.cpu_we_i && is_io && !misal;
    be      = bus.cpu_amp_i << off;
    wsh     = bus.cpu_wdata_i << sh;
    io_word = {bus.cpu_addr_i[15:2], 2'b00};

    bus.ram_addr_o  = bus.cpu_addr_i[RAM_AW+1:2];
    bus.ram_be_o    = be;
    bus.ram_wdata_o = wsh;
    bus.ram_we_o    = bus.cpu_we_i && is_ram && !misal;

    sel_seg7   = io_we && (io_word == {8'h00, OFF_SEG7});
    sel_led    = io_we && (io_word == {8'h00, OFF_LED});
    sel_timer  = io_we && (io_word == {8'h00, OFF_TIMER});
    sel_cmp    = io_we && (io_word == {8'h00, OFF_CMP});
    sel_status = io_we && (io_word == {8'h00, OFF_STATUS});
    sel_ctrl   = io_we && (io_word == {8'h00, OFF_CTRL});
  end

  // I/O read mux and final load-data selection.
  always_comb begin
    sw_word = '0;
    sw_word[SW_W-1:0] = sw_db;
    led_word = '0;
    led_word[LED_W-1:0] = led_o;
    io_rd = '0;
    case (io_word)
      {8'h00, OFF_SW}:     io_rd = sw_word;
      {8'h00, OFF_SEG7}:   io_rd = seg7_data_o;
      {8'h00, OFF_LED}:    io_rd = led_word;
      {8'h00, OFF_TIMER}:  io_rd = timer;
      {8'h00, OFF_CMP}:    io_rd = cmp;
      {8'h00, OFF_STATUS}: io_rd = {29'd0, status};
      {8'h00, OFF_CTRL}:   io_rd = {28'd0, ctrl};
      default:             io_rd = '0;
    endcase
    if (!ok)        bus.cpu_rdata_o = '0;
    else if (is_io) bus.cpu_rdata_o = io_rd >> sh;
    else            bus.cpu_rdata_o = bus.ram_rdata_i >> sh;
  end

  // Flag set/clear terms; a set in the same cycle overrides the W1C.
  always_comb begin
    match_hit = ctrl[CT_TEN] && (timer == cmp);
    st_set    = '0;
    st_set[ST_MATCH] = match_hit;
    st_set[ST_SWCHG] = sw_chg;
    st_set[ST_ERR]   = err_wr;
    st_clr = sel_status ? (wsh[2:0] & {3{be[0]}}) : 3'b000;
  end

  // Plain read/write registers: SEG7, LED, CMP, CTRL.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg7_data_o <= '0;
      led_o       <= '0;
      cmp         <= '0;
      ctrl        <= '0;
    end else begin
      if (sel_seg7) seg7_data_o <= lane_merge(seg7_data_o, wsh, be);
      if (sel_led)  led_o       <= LED_W'(lane_merge(led_word, wsh, be));
      if (sel_cmp)  cmp         <= lane_merge(cmp, wsh, be);
      if (sel_ctrl) ctrl        <= 4'(lane_merge({28'd0, ctrl}, wsh, be));
    end
  end

  // Free-running timer; a CPU write takes priority over the increment.
  always_ff @(posedge clk) begin
    if (rst)                timer <= '0;
    else if (sel_timer)     timer <= lane_merge(timer, wsh, be);
    else if (ctrl[CT_TEN])  timer <= timer + 32'd1;
  end

  // Sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) status <= '0;
    else     status <= (status & ~st_clr) | st_set;
  end

  // Registered interrupt level and SEG7 update strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_o     <= 1'b0;
      seg7_we_o <= 1'b0;
    end else begin
      irq_o <= (status[ST_MATCH] & ctrl[CT_IE_MATCH]) |
               (status[ST_SWCHG] & ctrl[CT_IE_SWCHG]) |
               (status[ST_ERR]   & ctrl[CT_IE_ERR]);
      seg7_we_o <= sel_seg7;
    end
  end

endmodule

// File: doc/mmio_hub.md
# mmio_hub

Parametrised memory-mapped I/O hub between the CPU data port and the data RAM, switches, LEDs and 7-segment display register. It adds a debounced switch port, a programmable timer with compare, sticky status flags, alignment checking and a level interrupt. It sits between the CPU's `Addr_out`/`Data_out`/`Data_in`/`mem_w` port and `dmem`/`SEG7x16` in the board top, and serves as the successor to the fixed MIO bus.

## Interface

Parameters:
- `RAM_AW`, default 7: RAM word-address width. The RAM spans bytes 0 .. 4·2^RAM_AW−1.
- `IO_BASE`, default 32'hFFFF_0000: I/O region base. Any address with [31:16] equal to IO_BASE[31:16] is I/O.
- `SW_W`, default 16: switch count.
- `LED_W`, default 16: LED count.
- `DEB_CYCLES`, default 16: number of stable cycles required before a switch change is accepted.

Ports:
- One clock; reset is synchronous and active-high.
- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `cpu_we_i`, in, 1: write strobe, one cycle per store.
- `cpu_addr_i`, in, 32: byte address.
- `cpu_wdata_i`, in, 32: store data, right-aligned.
- `cpu_amp_i`, in, 4: access pattern. 1111 is word, 0011 is half, 0001 is byte.
- `cpu_rdata_o`, out, 32: load data, right-aligned.
- `ram_we_o`, out, 1: RAM write enable.
- `ram_be_o`, out, 4: RAM byte enables.
- `ram_addr_o`, out, RAM_AW: RAM word address.
- `ram_wdata_o`, out, 32: lane-shifted write data.
- `ram_rdata_i`, in, 32: RAM read word (asynchronous read).
- `sw_i`, in, SW_W: raw switches (asynchronous).
- `led_o`, out, LED_W: LED register.
- `seg7_data_o`, out, 32: display register.
- `seg7_we_o`, out, 1: one-cycle pulse after a SEG7 write.
- `irq_o`, out, 1: level interrupt.

## Operation

Address decode:
- Region is IO, RAM (address < 4·2^RAM_AW) or unmapped.
- Let `off` = `cpu_addr_i[1:0]`.
- An access is misaligned when:
  - a half access has `off` = 3, or
  - a word access has `off` ≠ 0.
- Misaligned and unmapped accesses are errors:
  - the write is dropped,
  - the read returns 0,
  - STATUS.ERR is set.

RAM path (combinational):
- `ram_addr_o` = `addr[RAM_AW+1:2]`.
- `ram_be_o` = `amp << off`.
- `ram_wdata_o` = `wdata << 8·off`.
- `ram_we_o` = `cpu_we_i` && RAM && aligned.
- Read data = `ram_rdata_i >> 8·off`. The CPU performs sign/zero extension.

I/O register map, word offsets from IO_BASE. Sub-word access is allowed and byte lanes apply.
- 0x00 SW, read-only: debounced switches, zero-extended.
- 0x04 SEG7, read/write: display data, byte-lane writable.
- 0x08 LED, read/write: bits [LED_W−1:0]. Upper bits read 0.
- 0x0C TIMER, read/write: 32-bit counter.
- 0x10 CMP, read/write: compare value.
- 0x14 STATUS, read / write-1-to-clear:
  - bit0 MATCH,
  - bit1 SWCHG,
  - bit2 ERR.
- 0x18 CTRL, read/write:
  - bit0 TEN (timer enable),
  - bit1 IE_MATCH,
  - bit2 IE_SWCHG,
  - bit3 IE_ERR.
- Other offsets in the I/O region read 0 and ignore writes. They are not errors.

Timer:
- While TEN=1, TIMER increments by 1 each cycle and wraps from FFFF_FFFF to 0.
- A CPU write to TIMER has priority over the increment.
- MATCH is set at the edge after a cycle where TEN=1 and the current TIMER equals CMP.

Switch debounce:
- `sw_i` passes through a 2-flop synchroniser.
- If the synchronised value differs from the current candidate, the candidate is reloaded and the counter cleared.
- Otherwise the counter counts up. When it reaches DEB_CYCLES−1:
  - SW takes the candidate value;
  - SWCHG is set if SW changed.

Interrupt:
- `irq_o` = (MATCH & IE_MATCH) | (SWCHG & IE_SWCHG) | (ERR & IE_ERR).
- `irq_o` is registered from the status and control state.

Flag and write precedence:
- In any cycle, a hardware flag set wins over a write-1-to-clear of the same bit.

## Timing

Latency:
- All reads are combinational, with same-cycle data. RAM timing matches `dmem`.
- Register writes take effect at the rising edge where `cpu_we_i`=1.
- `seg7_we_o` goes high for exactly the cycle after a SEG7 write edge. `seg7_data_o` is already updated in that cycle.
- `irq_o` reflects flags one cycle after they are set or cleared.
- A switch change reaches SW within 2 + DEB_CYCLES cycles of a stable input.

Reset values:
- All registers, flags, SW, counters and synchronisers are 0.
- `led_o`=0, `seg7_data_o`=0, `seg7_we_o`=0, `irq_o`=0.

Reset mid-operation:
- A pending write is discarded.
- An in-progress debounce is abandoned.

## Structure

- Package `mmio_pkg` holds:
  - register offsets (`OFF_SW` … `OFF_CTRL`),
  - STATUS/CTRL bit indices,
  - access-pattern constants `AMP_W`, `AMP_H`, `AMP_B`.
- Sub-module `sw_debounce`, parameters `W` and `CYCLES`:
  - ports `clk`, `rst`, `raw_i`, `db_o`, `chg_o`;
  - `chg_o` is a one-cycle pulse;
  - instantiated once.
- Everything else lives in `mmio_hub`.

## Test plan

1. Store word 0xDEADBEEF to RAM 0x10, then byte load from 0x13.
   - Store: `ram_be_o`=1111, `ram_addr_o`=4.
   - Load: `cpu_rdata_o[7:0]`=0xDE.
2. Half store of 0x1234 to 0x22.
   - `ram_be_o`=1100, `ram_wdata_o`=0x1234_0000.
   - Then a half store to 0x23: no write, STATUS=0x4.
3. Byte store 0xAB to IO_BASE+0x05.
   - SEG7=0x0000_AB00.
   - `seg7_we_o` is high for exactly one cycle after the edge.
4. Program CMP=5, CTRL=0x3, TIMER=0.
   - MATCH sets after 6 enabled cycles and `irq_o` rises.
   - Writing STATUS=1 clears both MATCH and `irq_o`.
5. Toggle `sw_i[0]` with a 3-cycle glitch, then hold it high (DEB_CYCLES=16).
   - The glitch is ignored.
   - SW reads 0x1 and SWCHG sets 18 cycles after the hold begins.
6. Assert `rst` in the cycle of a TIMER write with TEN=1.
   - TIMER=0, CTRL=0, `irq_o`=0 the next cycle.
